// File: rtl/hex_led_ctrl.sv
// Avalon-MM display controller for six seven-segment digits and ten red LEDs.
// Holds CPU-written display state, decodes hex nibbles and runs a prescaled blink timer.
module hex_led_ctrl #(
    parameter int BLINK_HALF_PERIOD = 12_500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [9:0]  ledr
);

    localparam logic [2:0]  ADDR_CTRL   = 3'd0;
    localparam logic [2:0]  ADDR_VALUE  = 3'd1;
    localparam logic [2:0]  ADDR_RAW_LO = 3'd2;
    localparam logic [2:0]  ADDR_RAW_HI = 3'd3;
    localparam logic [2:0]  ADDR_LED    = 3'd4;
    localparam logic [2:0]  ADDR_STATUS = 3'd5;
    localparam logic [23:0] CNT_LAST    = 24'(BLINK_HALF_PERIOD - 1);
    localparam logic [6:0]  SEG_OFF     = 7'h7F;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

    logic [8:0]       ctrl_q,   ctrl_d;
    logic [23:0]      value_q,  value_d;
    logic [27:0]      raw_lo_q, raw_lo_d;
    logic [13:0]      raw_hi_q, raw_hi_d;
    logic [9:0]       led_q,    led_d;
    logic [23:0]      cnt_q,    cnt_d;
    logic             phase_q,  phase_d;
    logic [5:0][6:0]  hex_q,    hex_d;
    logic [9:0]       ledr_q,   ledr_d;
    logic [31:0]      rdata_q,  rdata_d;
    logic             rvalid_q, rvalid_d;

    logic             ctrl_wr_s;
    logic [41:0]      raw_all_s;
    logic [31:0]      rd_mux_s;
    logic             unused_wdata_s;

    assign ctrl_wr_s      = avs_write && (avs_address == ADDR_CTRL);
    assign raw_all_s      = {raw_hi_q, raw_lo_q};
    assign unused_wdata_s = ^avs_writedata[31:28];

    // Register file write decode
    always_comb begin
        ctrl_d   = ctrl_q;
        value_d  = value_q;
        raw_lo_d = raw_lo_q;
        raw_hi_d = raw_hi_q;
        led_d    = led_q;
        if (avs_write) begin
            case (avs_address)
                ADDR_CTRL:   ctrl_d   = avs_writedata[8:0];
                ADDR_VALUE:  value_d  = avs_writedata[23:0];
                ADDR_RAW_LO: raw_lo_d = avs_writedata[27:0];
                ADDR_RAW_HI: raw_hi_d = avs_writedata[13:0];
                ADDR_LED:    led_d    = avs_writedata[9:0];
                default:     ctrl_d   = ctrl_q;
            endcase
        end else begin
            ctrl_d = ctrl_q;
        end
    end

    // Blink prescaler; a CTRL write restarts the pattern from phase 0
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (ctrl_wr_s) begin
            cnt_d   = 24'd0;
            phase_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = 24'd0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + 24'd1;
            phase_d = phase_q;
        end
    end

    // Read mux samples pre-write state so a same-cycle write is not visible
    always_comb begin
        rd_mux_s = 32'd0;
        case (avs_address)
            ADDR_CTRL:   rd_mux_s = {23'd0, ctrl_q};
            ADDR_VALUE:  rd_mux_s = {8'd0, value_q};
            ADDR_RAW_LO: rd_mux_s = {4'd0, raw_lo_q};
            ADDR_RAW_HI: rd_mux_s = {18'd0, raw_hi_q};
            ADDR_LED:    rd_mux_s = {22'd0, led_q};
            ADDR_STATUS: rd_mux_s = {7'd0, cnt_q, phase_q};
            default:     rd_mux_s = 32'd0;
        endcase
        rvalid_d = avs_read;
        if (avs_read) begin
            rdata_d = rd_mux_s;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Pin selection: blanking, raw pattern or decoded nibble per digit
    always_comb begin
        hex_d = {6{SEG_OFF}};
        for (int i = 0; i < 6; i++) begin
            if (!ctrl_q[0] || (ctrl_q[2 + i] && phase_q)) begin
                hex_d[i] = SEG_OFF;
            end else if (ctrl_q[1]) begin
                hex_d[i] = raw_all_s[7*i +: 7];
            end else begin
                hex_d[i] = seg_decode(value_q[4*i +: 4]);
            end
        end
        if (ctrl_q[8] && phase_q) begin
            ledr_d = 10'd0;
        end else begin
            ledr_d = led_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q   <= 9'd0;
            value_q  <= 24'd0;
            raw_lo_q <= 28'd0;
            raw_hi_q <= 14'd0;
            led_q    <= 10'd0;
            cnt_q    <= 24'd0;
            phase_q  <= 1'b0;
            hex_q    <= {6{SEG_OFF}};
            ledr_q   <= 10'd0;
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            value_q  <= value_d;
            raw_lo_q <= raw_lo_d;
            raw_hi_q <= raw_hi_d;
            led_q    <= led_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            hex_q    <= hex_d;
            ledr_q   <= ledr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign hex0              = hex_q[0];
    assign hex1              = hex_q[1];
    assign hex2              = hex_q[2];
    assign hex3              = hex_q[3];
    assign hex4              = hex_q[4];
    assign hex5              = hex_q[5];
    assign ledr              = ledr_q;
    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;

endmodule

// File: tb/tb_hex_led_ctrl.sv
// Scoreboard bench for hex_led_ctrl: a register-level model predicts pins and read beats,
// a monitor on the falling edge compares them against the DUT.
module tb_hex_led_ctrl;

    localparam int HP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [9:0]  ledr;

    always #5 clk = ~clk;

    hex_led_ctrl #(.BLINK_HALF_PERIOD(HP)) dut (
        .clk(clk), .rst(rst),
        .avs_address(avs_address), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_read(avs_read),
        .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
        .ledr(ledr)
    );

    typedef struct packed {
        logic [5:0][6:0] hex;
        logic [9:0]      led;
        logic            rdv;
        logic [31:0]     rd;
    } pin_t;

    pin_t        pin_q[$];
    logic [31:0] rd_q[$];
    int          checks = 0;
    int          errors = 0;

    logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [8:0]  m_ctrl = 9'd0;
    logic [23:0] m_value = 24'd0;
    logic [6:0]  m_raw [6];
    logic [9:0]  m_led = 10'd0;
    int          m_cnt = 0;
    bit          m_phase = 1'b0;
    logic [31:0] m_last_rd = 32'd0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return {23'd0, m_ctrl};
            3'd1:    return {8'd0, m_value};
            3'd2:    return {4'd0, m_raw[3], m_raw[2], m_raw[1], m_raw[0]};
            3'd3:    return {18'd0, m_raw[5], m_raw[4]};
            3'd4:    return {22'd0, m_led};
            3'd5:    return {7'd0, 24'(m_cnt), m_phase};
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: one step per rising edge, pins derived from the state before the edge
    always @(posedge clk) begin : model
        pin_t p;
        if (rst) begin
            m_ctrl = 9'd0; m_value = 24'd0; m_led = 10'd0;
            for (int i = 0; i < 6; i++) m_raw[i] = 7'd0;
            m_cnt = 0; m_phase = 1'b0; m_last_rd = 32'd0;
            rd_q.delete();
            p.hex = {6{7'h7F}}; p.led = 10'd0; p.rdv = 1'b0; p.rd = 32'd0;
            pin_q.push_back(p);
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (!m_ctrl[0] || (m_ctrl[2 + i] && m_phase)) p.hex[i] = 7'h7F;
                else if (m_ctrl[1])                            p.hex[i] = m_raw[i];
                else                                           p.hex[i] = seg_tab[m_value[4*i +: 4]];
            end
            p.led = (m_ctrl[8] && m_phase) ? 10'd0 : m_led;
            p.rdv = avs_read;
            if (avs_read) begin
                m_last_rd = model_read(avs_address);
                rd_q.push_back(m_last_rd);
            end
            p.rd = m_last_rd;
            pin_q.push_back(p);
            if (avs_write) begin
                case (avs_address)
                    3'd0: m_ctrl  = avs_writedata[8:0];
                    3'd1: m_value = avs_writedata[23:0];
                    3'd2: for (int i = 0; i < 4; i++) m_raw[i] = avs_writedata[7*i +: 7];
                    3'd3: begin m_raw[4] = avs_writedata[6:0]; m_raw[5] = avs_writedata[13:7]; end
                    3'd4: m_led   = avs_writedata[9:0];
                    default: ;
                endcase
            end
            if (avs_write && avs_address == 3'd0) begin
                m_cnt = 0; m_phase = 1'b0;
            end else begin
                m_cnt = m_cnt + 1;
                if (m_cnt == HP) begin m_cnt = 0; m_phase = !m_phase; end
            end
        end
    end

    // Monitor: compares pins every cycle, pops a read beat whenever the DUT presents one
    always @(negedge clk) begin : monitor
        pin_t p;
        logic [31:0] exp_rd;
        if (pin_q.size() > 0) begin
            p = pin_q.pop_front();
            chk("hex", {hex5, hex4, hex3, hex2, hex1, hex0}, p.hex);
            chk("ledr", ledr, p.led);
            chk("readdatavalid", avs_readdatavalid, p.rdv);
            if (avs_readdatavalid) begin
                if (rd_q.size() == 0) begin
                    chk("unexpected_read_beat", 1'b1, 1'b0);
                end else begin
                    exp_rd = rd_q.pop_front();
                    chk("readdata", avs_readdata, exp_rd);
                end
            end else begin
                chk("readdata_hold", avs_readdata, p.rd);
            end
        end
    end

    task automatic cyc(input logic r, input logic w, input logic rd,
                       input logic [2:0] a, input logic [31:0] d);
        rst = r; avs_write = w; avs_read = rd; avs_address = a; avs_writedata = d;
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, 1'b0, a, d);
    endtask

    task automatic rdr(input logic [2:0] a);
        cyc(1'b0, 1'b0, 1'b1, a, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    initial begin : stim
        int n;
        int r;
        logic [2:0] a;
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
        chk("reset_hex0", hex0, 7'h7F);
        chk("reset_ledr", ledr, 10'd0);
        for (int i = 0; i < 6; i++) rdr(3'(i));
        idle(2);

        wr(3'd1, 32'h00FEDCBA); wr(3'd0, 32'h1); idle(2);
        chk("dec_hex0", hex0, 7'h08); chk("dec_hex1", hex1, 7'h03);
        chk("dec_hex2", hex2, 7'h46); chk("dec_hex3", hex3, 7'h21);
        chk("dec_hex4", hex4, 7'h06); chk("dec_hex5", hex5, 7'h0E);
        wr(3'd1, 32'h00543210); idle(2);
        chk("dec2_hex0", hex0, 7'h40); chk("dec2_hex5", hex5, 7'h12);

        wr(3'd2, 32'h0); wr(3'd3, 32'h3FFF); wr(3'd0, 32'h3); idle(2);
        chk("raw_hex3", hex3, 7'h00); chk("raw_hex4", hex4, 7'h7F);
        wr(3'd0, 32'h2); idle(2);
        chk("dis_hex0", hex0, 7'h7F);

        wr(3'd4, 32'h3FF); wr(3'd0, 32'h105); idle(13);
        wr(3'd0, 32'h105); idle(12);

        wr(3'd4, 32'h155); idle(1);
        cyc(1'b0, 1'b1, 1'b1, 3'd4, 32'h2AA); idle(2);
        chk("rw_ledr", ledr | {9'd0, m_phase ? 1'b1 : 1'b0}, m_phase ? 10'h2AB : 10'h2AA);
        rdr(3'd1); rdr(3'd4); rdr(3'd7); idle(2);

        n = 0;
        while (!m_phase && n < 20) begin idle(1); n++; end
        chk("phase_wait", m_phase, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
        chk("midrst_hex0", hex0, 7'h7F);
        chk("midrst_ledr", ledr, 10'd0);
        rdr(3'd5); idle(2);

        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 199);
            a = 3'($urandom_range(0, 7));
            if (a == 3'd0 && $urandom_range(0, 3) != 0) a = 3'd1;
            if (r == 0) cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
            else cyc(1'b0, r < 60, ($urandom_range(0, 1) == 1), a, $urandom);
        end
        idle(3);
        chk("read_queue_drained", 32'(rd_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_led_ctrl.md
# hex_led_ctrl

Memory-mapped display controller: an Avalon-MM slave, exported from `cpu_subsystem`, that owns the board's six seven-segment digits (HEX0–HEX5) and ten red LEDs (LEDR). It holds the CPU-written display state and decodes hex nibbles to active-low segment patterns. It also runs a prescaled blink timer, so that software never drives the pins directly. The top level replaces its constant tie-offs on HEX*/LEDR with this block's outputs.

## Interface
Parameters:
- `BLINK_HALF_PERIOD`, default 12_500_000, clk cycles per blink phase (4 Hz toggle, 2 Hz blink at 50 MHz); legal range 2..2^24.

Ports:
- `clk`  in  1  system clock (CLOCK_50 domain).
- `rst`  in  1  reset; synchronous, active-high.
- `avs_address`  in  3  word address.
- `avs_write`  in  1  write strobe.
- `avs_writedata`  in  32  write data.
- `avs_read`  in  1  read strobe.
- `avs_readdata`  out  32  read data, fixed read latency 1.
- `avs_readdatavalid`  out  1  high for one cycle with `avs_readdata`.
- `hex0`..`hex5`  out  7 each  active-low segments; bit0=a … bit6=g.
- `ledr`  out  10  active-high LEDs.

## Operation
- Register map (word address), fields not listed read as 0 and writes to them are ignored:
  - 0 CTRL: [0] EN (1 = digits lit); [1] RAW (1 = digits from RAW regs, 0 = decode VALUE); [7:2] BLINK_MASK (bit i blinks HEXi); [8] LED_BLINK.
  - 1 VALUE: [23:0] nibble i → HEXi.
  - 2 RAW_LO: [6:0] HEX0, [13:7] HEX1, [20:14] HEX2, [27:21] HEX3, in active-low pattern.
  - 3 RAW_HI: [6:0] HEX4, [13:7] HEX5.
  - 4 LED: [9:0] LEDR value.
  - 5 STATUS (read-only): [0] blink phase; [24:1] blink counter.
  - 6, 7: read 0; writes ignored.
- Decode (nibble → segments): 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E (hex).
- Digit i output selection:
  - 7F when EN=0, or when BLINK_MASK[i]=1 and phase=1.
  - Otherwise the RAW field if RAW=1, or the decoded nibble if RAW=0.
- `ledr` = LED reg, except 0 when LED_BLINK=1 and phase=1.
- Blink timer:
  - Counter runs 0..BLINK_HALF_PERIOD-1, then wraps to 0 and phase toggles.
  - The timer runs regardless of EN.
  - Any write to CTRL clears the counter and phase to 0 in the same edge.
- Reset values: all registers 0, counter 0, phase 0, `hex*` = 7F, `ledr` = 0, `avs_readdata` = 0, `avs_readdatavalid` = 0.

## Timing
- Write: sampled on the rising edge where `avs_write`=1; the register holds the new value after that edge. No waitrequest; every access completes.
- Pin outputs are registered. `hex*`/`ledr` reflect a write one cycle after the write edge, i.e. 2 edges after the write is presented.
- Read: `avs_read` sampled at edge k. `avs_readdata`/`avs_readdatavalid` are valid after edge k and drop after edge k+1 unless another read is presented. `avs_readdata` holds its last value when not valid.
- Simultaneous read and write to the same address: write is applied, read returns the pre-write value.
- Back-to-back reads: one result per cycle, in order.
- Phase toggle: toggles on the edge where counter = BLINK_HALF_PERIOD-1. Affected outputs change one edge later.
- Mid-operation `rst` assertion overrides everything on that edge, including a concurrent write or read; no readdatavalid follows.

## Test plan
- Reset: hold `rst` 2 cycles → all `hex*`=7F, `ledr`=0, `avs_readdatavalid`=0; then read addr 0..5 → all return 0 at latency 1.
- Decode: write VALUE=0x00FEDCBA, CTRL=0x1 → 2 cycles later hex0=08, hex1=03, hex2=46, hex3=21, hex4=06, hex5=0E; then VALUE=0x00543210 → hex0..5 = 40,79,24,30,19,12.
- Raw/enable: write RAW_LO=0x0, RAW_HI=0x3FFF, CTRL=0x3 → hex0–3=00, hex4–5=7F; write CTRL=0x2 → all 7F.
- Blink (BLINK_HALF_PERIOD=4): CTRL=0x1|(1<<2)|(1<<8), LED=0x3FF → hex0 and ledr alternate visible/off every 4 cycles; other digits are steady. A CTRL rewrite mid-period restarts the phase at 0.
- Bus corner: same-cycle read+write on addr 4 (old 0x155, new 0x2AA) → readdata=0x155, `ledr`=2AA; back-to-back reads of addr 1,4,7 → three consecutive valid beats returning VALUE, 0x2AA, 0.
- Reset mid-blink: assert `rst` while phase=1 → next edge outputs 7F/0 and STATUS reads 0.
